// File: rtl/adder_8_pkg.sv
// Shared definitions for the registered unsigned adder and related arithmetic blocks.
package adder_8_pkg;

  localparam int unsigned ADDER_WIDTH_DEFAULT = 8;

  // Status flags produced alongside a sum.
  typedef struct packed {
    logic zero;
    logic ovf;
  } adder_flags_t;

  // Two's-complement overflow: both operands share a sign and the result sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_8_if.sv
// Operand/result bundle for adder_8: the master issues operands, the slave returns results.
interface adder_8_if import adder_8_pkg::*; #(
  parameter int unsigned WIDTH = ADDER_WIDTH_DEFAULT
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH:0]   c;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin,
    input  out_valid, c, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, cin,
    output out_valid, c, zero, ovf
  );

endinterface

// File: rtl/adder_8_core.sv
// Combinational core: zero-extended add with carry-in plus zero and signed-overflow flags.
module adder_8_core import adder_8_pkg::*; #(
  parameter int unsigned WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum,
  output adder_flags_t     flags
);

  // Sum is WIDTH+1 bits wide, so the result is exact and never wraps.
  always_comb begin
    sum        = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    flags.zero = (sum == '0);
    flags.ovf  = signed_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
  end

endmodule

// File: rtl/adder_8.sv
// Registered unsigned adder: one-cycle latency, full-rate, valid-qualified, with status flags.
module adder_8 import adder_8_pkg::*; #(
  parameter int unsigned WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  adder_8_if.slave  bus
);

  logic [WIDTH:0] sum;
  adder_flags_t   flags;

  adder_8_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a     (bus.a),
    .b     (bus.b),
    .cin   (bus.cin),
    .sum   (sum),
    .flags (flags)
  );

  // Result registers load only on a valid operand, so idle or undefined inputs never reach c.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.c         <= '0;
      bus.zero      <= 1'b1;
      bus.ovf       <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.c    <= sum;
        bus.zero <= flags.zero;
        bus.ovf  <= flags.ovf;
      end
    end
  end

endmodule

// File: tb/tb_adder_8.sv
// Self-checking bench for adder_8: directed vector table plus reset sequences.
module tb_adder_8;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  adder_8_if #(.WIDTH(8)) bus ();

  adder_8 #(
    .WIDTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       vld;
    logic [8:0] exp_c;
    logic       exp_zero;
    logic       exp_ovf;
    logic       exp_valid;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic cin,
                              input logic vld, input logic [8:0] c, input logic z,
                              input logic o, input logic v);
    vec_t r;
    r.a = a; r.b = b; r.cin = cin; r.vld = vld;
    r.exp_c = c; r.exp_zero = z; r.exp_ovf = o; r.exp_valid = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [8:0] c, input logic z,
                         input logic o, input logic v);
    chk({tag, ".c"},         {7'd0, bus.c},         {7'd0, c});
    chk({tag, ".zero"},      {15'd0, bus.zero},     {15'd0, z});
    chk({tag, ".ovf"},       {15'd0, bus.ovf},      {15'd0, o});
    chk({tag, ".out_valid"}, {15'd0, bus.out_valid}, {15'd0, v});
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(8'd1,   8'd0,   1'b0, 1'b1, 9'd1,   1'b0, 1'b0, 1'b1);
    tbl[1]  = mk(8'd1,   8'd10,  1'b0, 1'b1, 9'd11,  1'b0, 1'b0, 1'b1);
    tbl[2]  = mk(8'd3,   8'd99,  1'b0, 1'b1, 9'd102, 1'b0, 1'b0, 1'b1);
    tbl[3]  = mk(8'd101, 8'd66,  1'b0, 1'b1, 9'd167, 1'b0, 1'b1, 1'b1);
    tbl[4]  = mk(8'd255, 8'd255, 1'b0, 1'b1, 9'd510, 1'b0, 1'b0, 1'b1);
    tbl[5]  = mk(8'd255, 8'd255, 1'b1, 1'b1, 9'd511, 1'b0, 1'b0, 1'b1);
    tbl[6]  = mk(8'd0,   8'd0,   1'b0, 1'b1, 9'd0,   1'b1, 1'b0, 1'b1);
    tbl[7]  = mk(8'd0,   8'd255, 1'b1, 1'b1, 9'd256, 1'b0, 1'b0, 1'b1);
    tbl[8]  = mk(8'd127, 8'd1,   1'b0, 1'b1, 9'd128, 1'b0, 1'b1, 1'b1);
    tbl[9]  = mk(8'd128, 8'd128, 1'b0, 1'b1, 9'd256, 1'b0, 1'b1, 1'b1);
    tbl[10] = mk(8'd200, 8'd100, 1'b0, 1'b1, 9'd300, 1'b0, 1'b0, 1'b1);
    tbl[11] = mk(8'd10,  8'd20,  1'b0, 1'b1, 9'd30,  1'b0, 1'b0, 1'b1);
    tbl[12] = mk(8'hEE,  8'h77,  1'b1, 1'b0, 9'd30,  1'b0, 1'b0, 1'b0);
    tbl[13] = mk(8'h81,  8'hFF,  1'b1, 1'b0, 9'd30,  1'b0, 1'b0, 1'b0);
    tbl[14] = mk(8'd7,   8'd8,   1'b0, 1'b1, 9'd15,  1'b0, 1'b0, 1'b1);

    // Reset held two cycles with a valid operand present.
    rst = 1'b1;
    drive(1'b1, 8'd5, 8'd5, 1'b0);
    tick();
    chk_out("reset0", 9'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("reset1", 9'd0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // Back-to-back vectors; each result is checked one edge after its inputs.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].vld, tbl[i].a, tbl[i].b, tbl[i].cin);
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].exp_c, tbl[i].exp_zero,
              tbl[i].exp_ovf, tbl[i].exp_valid);
    end

    // Mid-stream reset: the operand accompanying reset is discarded.
    rst = 1'b1;
    drive(1'b1, 8'd50, 8'd60, 1'b0);
    tick();
    chk_out("midrst", 9'd0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 8'd50, 8'd60, 1'b0);
    tick();
    chk_out("midrst_idle", 9'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'd9, 8'd9, 1'b0);
    tick();
    chk_out("resume", 9'd18, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    tick();
    chk_out("resume_idle", 9'd18, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_8.md
Name: adder_8

Overview:
- Registered unsigned adder. Adds two WIDTH-bit operands (default 8) and produces a full WIDTH+1-bit sum, so carry-out is never lost.
- One-cycle pipelined arithmetic leaf block with a valid qualifier and status flags.
- Instantiated wherever a datapath needs a registered sum with carry, e.g. accumulators and address/offset adders.

Parameters:
- WIDTH, 8, operand width in bits; sum width is WIDTH+1; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  qualifies a, b and cin this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in added to a+b; tie 0 for a plain add.
- out_valid  output  1  c/zero/ovf hold a result launched the previous cycle.
- c  output  WIDTH+1  registered sum a+b+cin; MSB is carry-out.
- zero  output  1  registered; 1 when c == 0.
- ovf  output  1  registered signed overflow: a and b have the same MSB and sum bit WIDTH-1 differs from it.

Behaviour:
- Reset: while rst=1 at a rising edge, c=0, zero=1, ovf=0, out_valid=0. Reset overrides a simultaneous in_valid. An operation in flight when reset is asserted is discarded.
- Latency: exactly 1 cycle. Operands sampled at edge N with in_valid=1 appear on c at edge N, with out_valid=1 during the following cycle.
- Throughput: one operation per cycle, back-to-back, no stall.
- No ready/backpressure signal. The downstream block must take the result in the cycle out_valid=1.
- in_valid=0: out_valid goes 0 at the next edge. c, zero and ovf hold their last value and do not update.
- Arithmetic: zero-extend a and b to WIDTH+1 bits, then add them with cin. Result is exact; there is no wrap-around, because the maximum 2*(2^WIDTH-1)+1 fits in WIDTH+1 bits.
- Sum range:
  - 255+255+0 = 510 (0x1FE)
  - 255+255+1 = 511 (0x1FF)
  - 0+0+0 = 0, with zero=1.
- ovf is computed on the WIDTH-bit two's-complement view (bit WIDTH-1 of the sum). It is informational only and never affects c.
- The outputs are fully registered. There is no combinational path from the inputs to the outputs.
- X on a or b while in_valid=0 must not propagate into c.

Decomposition:
- Shared package adder_8_pkg:
  - ADDER_WIDTH_DEFAULT = 8.
  - Function for signed-overflow detection, reusable by other arithmetic blocks.
- One natural sub-module, adder_8_core: purely combinational, holding the zero-extend, add, zero and overflow logic.
- The adder_8 top owns the input qualification, output registers, valid pipeline and reset.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, a=5, b=5 -> c=0, zero=1, ovf=0, out_valid=0. The first result appears only after rst is released.
- Directed sequence, cin=0, one op per cycle:
  - (1,0) -> 1
  - (1,10) -> 11
  - (3,99) -> 102
  - (101,66) -> 167, ovf=1
  - (255,255) -> 510, carry bit c[8]=1, ovf=0
  - Each result follows its inputs by exactly 1 cycle, with out_valid=1 throughout.
- Carry-in boundaries: (255,255,cin=1) -> 511; (0,0,cin=0) -> 0 with zero=1; (0,255,cin=1) -> 256 with zero=0.
- Signed overflow: (127,1) -> 128 with ovf=1; (128,128) -> 256 with ovf=1; (200,100) -> 300 with ovf=0.
- Valid gaps: in_valid pattern 1,0,0,1 with (10,20), junk, junk, (7,8) -> out_valid pattern 1,0,0,1; c=30 held through the gap, then 15.
- Mid-stream reset: rst pulsed for 1 cycle while in_valid=1 with (50,60) -> out_valid=0 and c=0 the next cycle, and 110 is never presented. Normal operation resumes on the next valid input.
